reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) of the Tomasulo core. It receives instructions from the dispatcher and returns the next free tag.
- Answers the dispatcher's two operand-forwarding lookups.
- Captures results broadcast on the CDB.
- Retires one instruction per cycle to the regfile, the store buffer and the branch predictor, and raises a pipeline flush on branch misprediction.

Parameters:
- ROB_WIDTH, 4: tag width; tag 0 is reserved as "no dependency", so DEPTH-1 = 15 entries are usable (tags 1..15).
- ID_WIDTH, 32: data width.
- ADDR_WIDTH, 32: PC width.
- REG_WIDTH, 5: architectural register index width.
- OP_WIDTH, 6: instruction-type code width.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state and suppresses all pulses.
- dispatcher_rob_en_in  in  1  allocate one entry this cycle.
- dispatcher_rob_opcode_in  in  OP_WIDTH  instruction type.
- dispatcher_rob_dest_in  in  REG_WIDTH  destination register.
- dispatcher_rob_pc_in  in  ADDR_WIDTH  instruction PC.
- dispatcher_rob_taken_in  in  1  predicted taken.
- rob_dispatcher_b_out  out  ROB_WIDTH  tag that the next allocation receives (combinational from tail).
- rob_full_out  out  1  no free entry (combinational).
- dispatcher_rob_rs_h_in, dispatcher_rob_rt_h_in  in  ROB_WIDTH  lookup tags.
- rob_dispatcher_rs_ready_out, rob_dispatcher_rt_ready_out  out  1  value available.
- rob_dispatcher_rs_value_out, rob_dispatcher_rt_value_out  out  ID_WIDTH  value.
- cdb_rob_en_in  in  1  result broadcast.
- cdb_rob_tag_in  in  ROB_WIDTH  producing tag.
- cdb_rob_value_in  in  ID_WIDTH  result.
- cdb_rob_taken_in  in  1  actual branch outcome.
- cdb_rob_target_in  in  ADDR_WIDTH  actual next PC for branches and jumps.
- rob_regfile_en_out  out  1  commit write pulse.
- rob_regfile_rd_out  out  REG_WIDTH  register written.
- rob_regfile_value_out  out  ID_WIDTH  value written.
- rob_regfile_tag_out  out  ROB_WIDTH  committing tag; the regfile clears busy only on a tag match.
- rob_lsb_store_en_out  out  1  store-commit pulse.
- rob_lsb_store_tag_out  out  ROB_WIDTH  store tag.
- rob_bp_en_out  out  1  predictor-update pulse.
- rob_bp_pc_out  out  ADDR_WIDTH  branch PC.
- rob_bp_taken_out  out  1  actual outcome.
- rob_flush_out  out  1  mispredict flush pulse.
- rob_pc_target_out  out  ADDR_WIDTH  redirect PC.

Behaviour:
- Entry fields: busy, ready, opcode, dest, pc, pred_taken, value, act_taken, target.
- Pointer state: head, tail (both ROB_WIDTH bits, values 1..DEPTH-1) and count (0..DEPTH-1).
- Reset (rst_in low, asynchronous):
  - head = tail = 1, count = 0, all busy = 0.
  - All registered outputs (every *_en_out, rob_flush_out, rd/value/tag/pc/target outputs) are 0.
- Pointer advance: incrementing from DEPTH-1 wraps to 1; tag 0 is never allocated.
- Full / empty: full is count == DEPTH-1; empty is count == 0.
- Allocate, when rdy_in & en & !full:
  - Write the entry at tail with busy = 1, ready = 0; tail advances.
  - Allocate while full is a protocol violation; it is dropped and a simulation assertion fires.
- CDB capture, when rdy_in & cdb_en & busy[tag]:
  - Store value, act_taken and target; set ready = 1.
  - A broadcast to a non-busy tag is ignored.
- Lookup (combinational):
  - ready_out = (busy[h] & ready[h]) | (cdb_en & cdb_tag == h). CDB bypass takes precedence; value is taken from the CDB in that case.
  - h == 0 yields ready = 0, value = 0.
- Commit, when rdy_in & count != 0 & ready[head] (at most one per cycle): registered outputs pulse for exactly one cycle.
  - Register writers: rob_regfile_en_out = 1 if dest != 0, with rd, value and tag = head.
  - Stores: rob_lsb_store_en_out with tag = head; no regfile write.
  - Conditional branches:
    - rob_bp_en_out with pc and act_taken.
    - If act_taken != pred_taken: rob_flush_out = 1 and rob_pc_target_out = target.
  - JALR: writes rd and always flushes to target. JAL writes rd and never flushes.
  - head advances and busy[head] clears.
- Flush: in the flush cycle, all state returns to the reset values (head = tail = 1, count = 0, busy cleared). An allocate or CDB write in the same cycle is discarded.
- Simultaneous allocate and commit: count is unchanged. Allocate is permitted when full if a non-flushing commit happens the same cycle? No: full is evaluated pre-edge, so allocate is refused.
- Latency: the entry is allocated at edge N. CDB capture takes effect at edge N+1 at the earliest, and commit outputs are visible after edge N+2.
- rdy_in low: no state change, and all pulse outputs are 0 the following cycle.

Decomposition:
- Shared constants package holds:
  - opcode codes (NOP, BRANCH class, STORE class, JAL, JALR);
  - helper functions is_branch, is_store, writes_rd;
  - width macros (ROBWidth, IDWidth, RegWidth, AddressWidth, InstTypeWidth).
- One natural sub-module, rob_lookup_port, instantiated twice for the rs and rt lookup with CDB bypass.

Test Plan:
- Reset then dispatch an ADD to x5 with pc = 0x100 → b_out is 1 then 2. CDB tag1 = 0x2A → the next cycle rob_regfile_en_out = 1, rd = 5, value = 0x2A, tag = 1.
- Dispatch 15 entries without CDB → rob_full_out = 1 and b_out wraps to 1. Commit head → full drops, and the next allocate gets tag 1.
- Lookup rs_h = 3 while the CDB broadcasts tag 3 = 0xDEAD the same cycle → ready = 1, value = 0xDEAD. Tag 3 is unbroadcast and not ready → ready = 0.
- Branch at pc = 0x200, predicted 0, CDB taken = 1, target = 0x240 → commit pulses bp_en (pc 0x200, taken 1), flush = 1 and pc_target = 0x240. Younger entries are discarded; count = 0 and b_out = 1.
- Out-of-order CDB (tag2 before tag1) → no commit until tag1 is ready, then tag1 and tag2 commit on consecutive cycles. A store entry yields rob_lsb_store_en_out only.
- Assert rst_in low mid-commit, and hold rdy_in low for 3 cycles with a ready head → all outputs are 0 immediately on reset. No commit occurs while rdy_in is low; the commit occurs after rdy_in rises.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, opcode codes and opcode-class helpers for the reorder buffer.
package reorder_buffer_pkg;
    localparam int ROBWidth      = 4;
    localparam int IDWidth       = 32;
    localparam int RegWidth      = 5;
    localparam int AddressWidth  = 32;
    localparam int InstTypeWidth = 6;

    localparam logic [InstTypeWidth-1:0] OP_NOP  = 6'd0;
    localparam logic [InstTypeWidth-1:0] OP_ALU  = 6'd1;
    localparam logic [InstTypeWidth-1:0] OP_LOAD = 6'd2;
    // Conditional branches occupy 16..21, stores 24..26.
    localparam logic [InstTypeWidth-1:0] OP_BEQ  = 6'd16;
    localparam logic [InstTypeWidth-1:0] OP_BNE  = 6'd17;
    localparam logic [InstTypeWidth-1:0] OP_BLT  = 6'd18;
    localparam logic [InstTypeWidth-1:0] OP_BGE  = 6'd19;
    localparam logic [InstTypeWidth-1:0] OP_BLTU = 6'd20;
    localparam logic [InstTypeWidth-1:0] OP_BGEU = 6'd21;
    localparam logic [InstTypeWidth-1:0] OP_SB   = 6'd24;
    localparam logic [InstTypeWidth-1:0] OP_SH   = 6'd25;
    localparam logic [InstTypeWidth-1:0] OP_SW   = 6'd26;
    localparam logic [InstTypeWidth-1:0] OP_JAL  = 6'd32;
    localparam logic [InstTypeWidth-1:0] OP_JALR = 6'd33;

    function automatic logic is_branch(input logic [InstTypeWidth-1:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic is_store(input logic [InstTypeWidth-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic writes_rd(input logic [InstTypeWidth-1:0] op);
        return (op != OP_NOP) && !is_branch(op) && !is_store(op);
    endfunction
endpackage

// File: rtl/reorder_buffer_lookup_port.sv
// One operand-forwarding lookup: CDB bypass first, then the captured entry value.
module rob_lookup_port
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROBWidth,
    parameter int ID_WIDTH  = IDWidth,
    localparam int DEPTH    = 1 << ROB_WIDTH
) (
    input  logic [ROB_WIDTH-1:0]             tag,
    input  logic                             cdb_en,
    input  logic [ROB_WIDTH-1:0]             cdb_tag,
    input  logic [ID_WIDTH-1:0]              cdb_value,
    input  logic [DEPTH-1:0]                 busy,
    input  logic [DEPTH-1:0]                 ready_bits,
    input  logic [DEPTH-1:0][ID_WIDTH-1:0]   values,
    output logic                             ready,
    output logic [ID_WIDTH-1:0]              value
);
    always_comb begin
        ready = 1'b0;
        value = '0;
        // Tag 0 means "no dependency" and never reports a value.
        if (tag != '0) begin
            if (cdb_en && (cdb_tag == tag)) begin
                ready = 1'b1;
                value = cdb_value;
            end else if (busy[tag] && ready_bits[tag]) begin
                ready = 1'b1;
                value = values[tag];
            end
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, captures CDB results,
// retires one entry per cycle and flushes on a branch/JALR redirect.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH  = ROBWidth,
    parameter int ID_WIDTH   = IDWidth,
    parameter int ADDR_WIDTH = AddressWidth,
    parameter int REG_WIDTH  = RegWidth,
    parameter int OP_WIDTH   = InstTypeWidth
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  dispatcher_rob_en_in,
    input  logic [OP_WIDTH-1:0]   dispatcher_rob_opcode_in,
    input  logic [REG_WIDTH-1:0]  dispatcher_rob_dest_in,
    input  logic [ADDR_WIDTH-1:0] dispatcher_rob_pc_in,
    input  logic                  dispatcher_rob_taken_in,
    output logic [ROB_WIDTH-1:0]  rob_dispatcher_b_out,
    output logic                  rob_full_out,
    input  logic [ROB_WIDTH-1:0]  dispatcher_rob_rs_h_in,
    input  logic [ROB_WIDTH-1:0]  dispatcher_rob_rt_h_in,
    output logic                  rob_dispatcher_rs_ready_out,
    output logic                  rob_dispatcher_rt_ready_out,
    output logic [ID_WIDTH-1:0]   rob_dispatcher_rs_value_out,
    output logic [ID_WIDTH-1:0]   rob_dispatcher_rt_value_out,
    input  logic                  cdb_rob_en_in,
    input  logic [ROB_WIDTH-1:0]  cdb_rob_tag_in,
    input  logic [ID_WIDTH-1:0]   cdb_rob_value_in,
    input  logic                  cdb_rob_taken_in,
    input  logic [ADDR_WIDTH-1:0] cdb_rob_target_in,
    output logic                  rob_regfile_en_out,
    output logic [REG_WIDTH-1:0]  rob_regfile_rd_out,
    output logic [ID_WIDTH-1:0]   rob_regfile_value_out,
    output logic [ROB_WIDTH-1:0]  rob_regfile_tag_out,
    output logic                  rob_lsb_store_en_out,
    output logic [ROB_WIDTH-1:0]  rob_lsb_store_tag_out,
    output logic                  rob_bp_en_out,
    output logic [ADDR_WIDTH-1:0] rob_bp_pc_out,
    output logic                  rob_bp_taken_out,
    output logic                  rob_flush_out,
    output logic [ADDR_WIDTH-1:0] rob_pc_target_out
);
    localparam int DEPTH = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] FIRST_TAG = ROB_WIDTH'(1);
    localparam logic [ROB_WIDTH-1:0] LAST_TAG  = ROB_WIDTH'(DEPTH - 1);

    function automatic logic [ROB_WIDTH-1:0] next_tag(input logic [ROB_WIDTH-1:0] t);
        return (t == LAST_TAG) ? FIRST_TAG : t + FIRST_TAG;
    endfunction

    logic [ROB_WIDTH-1:0] head, tail, count;
    logic [DEPTH-1:0]     busy, ready_bits;

    logic [DEPTH-1:0][OP_WIDTH-1:0]   opcode_q;
    logic [DEPTH-1:0][REG_WIDTH-1:0]  dest_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] pc_q;
    logic [DEPTH-1:0]                 pred_q;
    logic [DEPTH-1:0][ID_WIDTH-1:0]   value_q;
    logic [DEPTH-1:0]                 act_q;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] target_q;

    logic                full;
    logic [OP_WIDTH-1:0] head_op;
    logic                do_commit, do_flush, do_alloc, do_capture, mispredict;

    assign full      = (count == LAST_TAG);
    assign head_op   = opcode_q[head];
    assign do_commit = rdy_in && (count != '0) && ready_bits[head];
    assign mispredict = is_branch(head_op) && (act_q[head] != pred_q[head]);
    assign do_flush  = do_commit && (mispredict || (head_op == OP_JALR));
    // A redirect discards whatever else arrives in the same cycle.
    assign do_alloc   = rdy_in && dispatcher_rob_en_in && !full && !do_flush;
    assign do_capture = rdy_in && cdb_rob_en_in && busy[cdb_rob_tag_in] && !do_flush;

    assign rob_dispatcher_b_out = tail;
    assign rob_full_out         = full;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head       <= FIRST_TAG;
            tail       <= FIRST_TAG;
            count      <= '0;
            busy       <= '0;
            ready_bits <= '0;
        end else if (do_flush) begin
            head       <= FIRST_TAG;
            tail       <= FIRST_TAG;
            count      <= '0;
            busy       <= '0;
            ready_bits <= '0;
        end else begin
            if (do_alloc) begin
                busy[tail]       <= 1'b1;
                ready_bits[tail] <= 1'b0;
                tail             <= next_tag(tail);
            end
            if (do_capture) begin
                ready_bits[cdb_rob_tag_in] <= 1'b1;
            end
            if (do_commit) begin
                busy[head] <= 1'b0;
                head       <= next_tag(head);
            end
            if (do_alloc && !do_commit) begin
                count <= count + FIRST_TAG;
            end else if (!do_alloc && do_commit) begin
                count <= count - FIRST_TAG;
            end
        end
    end

    // Payload needs no reset: busy/ready gate every use of it.
    always_ff @(posedge clk_in) begin
        if (do_alloc) begin
            opcode_q[tail] <= dispatcher_rob_opcode_in;
            dest_q[tail]   <= dispatcher_rob_dest_in;
            pc_q[tail]     <= dispatcher_rob_pc_in;
            pred_q[tail]   <= dispatcher_rob_taken_in;
        end
        if (do_capture) begin
            value_q[cdb_rob_tag_in]  <= cdb_rob_value_in;
            act_q[cdb_rob_tag_in]    <= cdb_rob_taken_in;
            target_q[cdb_rob_tag_in] <= cdb_rob_target_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rob_regfile_en_out    <= 1'b0;
            rob_regfile_rd_out    <= '0;
            rob_regfile_value_out <= '0;
            rob_regfile_tag_out   <= '0;
            rob_lsb_store_en_out  <= 1'b0;
            rob_lsb_store_tag_out <= '0;
            rob_bp_en_out         <= 1'b0;
            rob_bp_pc_out         <= '0;
            rob_bp_taken_out      <= 1'b0;
            rob_flush_out         <= 1'b0;
            rob_pc_target_out     <= '0;
        end else begin
            rob_regfile_en_out   <= 1'b0;
            rob_lsb_store_en_out <= 1'b0;
            rob_bp_en_out        <= 1'b0;
            rob_flush_out        <= 1'b0;
            if (do_commit) begin
                if (writes_rd(head_op) && (dest_q[head] != '0)) begin
                    rob_regfile_en_out    <= 1'b1;
                    rob_regfile_rd_out    <= dest_q[head];
                    rob_regfile_value_out <= value_q[head];
                    rob_regfile_tag_out   <= head;
                end
                if (is_store(head_op)) begin
                    rob_lsb_store_en_out  <= 1'b1;
                    rob_lsb_store_tag_out <= head;
                end
                if (is_branch(head_op)) begin
                    rob_bp_en_out    <= 1'b1;
                    rob_bp_pc_out    <= pc_q[head];
                    rob_bp_taken_out <= act_q[head];
                end
                if (do_flush) begin
                    rob_flush_out     <= 1'b1;
                    rob_pc_target_out <= target_q[head];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && dispatcher_rob_en_in) begin
            assert (!full) else $error("reorder_buffer: allocate while full dropped");
        end
    end

    rob_lookup_port #(.ROB_WIDTH(ROB_WIDTH), .ID_WIDTH(ID_WIDTH)) u_rs_lookup (
        .tag        (dispatcher_rob_rs_h_in),
        .cdb_en     (cdb_rob_en_in),
        .cdb_tag    (cdb_rob_tag_in),
        .cdb_value  (cdb_rob_value_in),
        .busy       (busy),
        .ready_bits (ready_bits),
        .values     (value_q),
        .ready      (rob_dispatcher_rs_ready_out),
        .value      (rob_dispatcher_rs_value_out)
    );

    rob_lookup_port #(.ROB_WIDTH(ROB_WIDTH), .ID_WIDTH(ID_WIDTH)) u_rt_lookup (
        .tag        (dispatcher_rob_rt_h_in),
        .cdb_en     (cdb_rob_en_in),
        .cdb_tag    (cdb_rob_tag_in),
        .cdb_value  (cdb_rob_value_in),
        .busy       (busy),
        .ready_bits (ready_bits),
        .values     (value_q),
        .ready      (rob_dispatcher_rt_ready_out),
        .value      (rob_dispatcher_rt_value_out)
    );
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed and randomized checks of reorder_buffer against an in-order queue model.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy;
    logic        disp_en;
    logic [5:0]  disp_op;
    logic [4:0]  disp_dest;
    logic [31:0] disp_pc;
    logic        disp_taken;
    logic [3:0]  rs_h, rt_h;
    logic        cdb_en;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;

    logic [3:0]  b_out;
    logic        full_out;
    logic        rs_ready, rt_ready;
    logic [31:0] rs_value, rt_value;
    logic        reg_en;
    logic [4:0]  reg_rd;
    logic [31:0] reg_value;
    logic [3:0]  reg_tag;
    logic        st_en;
    logic [3:0]  st_tag;
    logic        bp_en;
    logic [31:0] bp_pc;
    logic        bp_taken;
    logic        flush;
    logic [31:0] pc_target;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  tag;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        pred;
        logic        rdy;
        logic [31:0] value;
        logic        act;
        logic [31:0] target;
    } ent_t;

    ent_t       rob_q[$];
    logic [3:0] m_tail = 4'd1;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk_in                      (clk),
        .rst_in                      (rst_n),
        .rdy_in                      (rdy),
        .dispatcher_rob_en_in        (disp_en),
        .dispatcher_rob_opcode_in    (disp_op),
        .dispatcher_rob_dest_in      (disp_dest),
        .dispatcher_rob_pc_in        (disp_pc),
        .dispatcher_rob_taken_in     (disp_taken),
        .rob_dispatcher_b_out        (b_out),
        .rob_full_out                (full_out),
        .dispatcher_rob_rs_h_in      (rs_h),
        .dispatcher_rob_rt_h_in      (rt_h),
        .rob_dispatcher_rs_ready_out (rs_ready),
        .rob_dispatcher_rt_ready_out (rt_ready),
        .rob_dispatcher_rs_value_out (rs_value),
        .rob_dispatcher_rt_value_out (rt_value),
        .cdb_rob_en_in               (cdb_en),
        .cdb_rob_tag_in              (cdb_tag),
        .cdb_rob_value_in            (cdb_value),
        .cdb_rob_taken_in            (cdb_taken),
        .cdb_rob_target_in           (cdb_target),
        .rob_regfile_en_out          (reg_en),
        .rob_regfile_rd_out          (reg_rd),
        .rob_regfile_value_out       (reg_value),
        .rob_regfile_tag_out         (reg_tag),
        .rob_lsb_store_en_out        (st_en),
        .rob_lsb_store_tag_out       (st_tag),
        .rob_bp_en_out               (bp_en),
        .rob_bp_pc_out               (bp_pc),
        .rob_bp_taken_out            (bp_taken),
        .rob_flush_out               (flush),
        .rob_pc_target_out           (pc_target)
    );

    function automatic logic m_branch(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic m_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic m_writer(input logic [5:0] op);
        return op inside {OP_ALU, OP_LOAD, OP_JAL, OP_JALR};
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; disp_en = 1'b0; disp_op = OP_NOP; disp_dest = '0; disp_pc = '0;
        disp_taken = 1'b0; rs_h = '0; rt_h = '0; cdb_en = 1'b0; cdb_tag = '0;
        cdb_value = '0; cdb_taken = 1'b0; cdb_target = '0;
    endtask

    task automatic check_lookup(input logic [3:0] h, input logic obs_r,
                                input logic [31:0] obs_v, input string nm);
        logic        er;
        logic [31:0] ev;
        er = 1'b0;
        ev = '0;
        if (h != 4'd0) begin
            if (cdb_en && cdb_tag == h) begin
                er = 1'b1;
                ev = cdb_value;
            end else begin
                foreach (rob_q[i]) begin
                    if (rob_q[i].tag == h && rob_q[i].rdy) begin
                        er = 1'b1;
                        ev = rob_q[i].value;
                    end
                end
            end
        end
        chk(32'(obs_r), 32'(er), {nm, "_ready"});
        if (er || h == 4'd0) chk(obs_v, ev, {nm, "_value"});
    endtask

    // One clock: check combinational outputs, predict the edge, check registered outputs.
    task automatic cycle();
        ent_t hd;
        ent_t ne;
        logic commit_now, e_reg, e_st, e_bp, e_fl;
        e_reg = 1'b0; e_st = 1'b0; e_bp = 1'b0; e_fl = 1'b0;
        hd = '0;
        #1;
        chk(32'(b_out), 32'(m_tail), "b_out");
        chk(32'(full_out), 32'(rob_q.size() == 15), "full");
        check_lookup(rs_h, rs_ready, rs_value, "rs");
        check_lookup(rt_h, rt_ready, rt_value, "rt");
        commit_now = 1'b0;
        if (rdy && rob_q.size() != 0) commit_now = rob_q[0].rdy;
        if (commit_now) begin
            hd    = rob_q[0];
            e_reg = m_writer(hd.op) && hd.dest != 5'd0;
            e_st  = m_store(hd.op);
            e_bp  = m_branch(hd.op);
            e_fl  = (e_bp && hd.act != hd.pred) || hd.op == OP_JALR;
        end
        @(posedge clk);
        #1;
        if (rdy) begin
            if (e_fl) begin
                rob_q.delete();
                m_tail = 4'd1;
            end else begin
                if (cdb_en) begin
                    foreach (rob_q[i]) begin
                        if (rob_q[i].tag == cdb_tag) begin
                            rob_q[i].rdy    = 1'b1;
                            rob_q[i].value  = cdb_value;
                            rob_q[i].act    = cdb_taken;
                            rob_q[i].target = cdb_target;
                        end
                    end
                end
                if (disp_en && rob_q.size() < 15) begin
                    ne = '0;
                    ne.tag = m_tail; ne.op = disp_op; ne.dest = disp_dest;
                    ne.pc = disp_pc; ne.pred = disp_taken;
                    rob_q.push_back(ne);
                    m_tail = (m_tail == 4'd15) ? 4'd1 : m_tail + 4'd1;
                end
                if (commit_now) void'(rob_q.pop_front());
            end
        end
        chk(32'(reg_en), 32'(e_reg), "regfile_en");
        chk(32'(st_en), 32'(e_st), "store_en");
        chk(32'(bp_en), 32'(e_bp), "bp_en");
        chk(32'(flush), 32'(e_fl), "flush");
        if (e_reg) begin
            chk(32'(reg_rd), 32'(hd.dest), "regfile_rd");
            chk(reg_value, hd.value, "regfile_value");
            chk(32'(reg_tag), 32'(hd.tag), "regfile_tag");
        end
        if (e_st) chk(32'(st_tag), 32'(hd.tag), "store_tag");
        if (e_bp) begin
            chk(bp_pc, hd.pc, "bp_pc");
            chk(32'(bp_taken), 32'(hd.act), "bp_taken");
        end
        if (e_fl) chk(pc_target, hd.target, "pc_target");
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk(32'(reg_en), 32'd0, "rst_regfile_en");
        chk(32'(reg_rd), 32'd0, "rst_regfile_rd");
        chk(reg_value, 32'd0, "rst_regfile_value");
        chk(32'(reg_tag), 32'd0, "rst_regfile_tag");
        chk(32'(st_en), 32'd0, "rst_store_en");
        chk(32'(st_tag), 32'd0, "rst_store_tag");
        chk(32'(bp_en), 32'd0, "rst_bp_en");
        chk(bp_pc, 32'd0, "rst_bp_pc");
        chk(32'(bp_taken), 32'd0, "rst_bp_taken");
        chk(32'(flush), 32'd0, "rst_flush");
        chk(pc_target, 32'd0, "rst_pc_target");
        chk(32'(b_out), 32'd1, "rst_b_out");
        chk(32'(full_out), 32'd0, "rst_full");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rob_q.delete();
        m_tail = 4'd1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [4:0] dest,
                        input logic [31:0] pc, input logic pred);
        idle();
        disp_en = 1'b1; disp_op = op; disp_dest = dest; disp_pc = pc; disp_taken = pred;
        cycle();
    endtask

    task automatic bcast(input logic [3:0] tag, input logic [31:0] value,
                         input logic taken, input logic [31:0] target);
        idle();
        cdb_en = 1'b1; cdb_tag = tag; cdb_value = value; cdb_taken = taken; cdb_target = target;
        cycle();
    endtask

    initial begin
        logic [5:0] ops[8];
        ops = '{OP_ALU, OP_LOAD, OP_BEQ, OP_BNE, OP_SW, OP_JAL, OP_JALR, OP_NOP};
        idle();
        @(negedge clk);
        do_reset();

        // Single ADD x5 retires with the broadcast value.
        disp(OP_ALU, 5'd5, 32'h100, 1'b0);
        chk(32'(b_out), 32'd2, "tp1_b_out_after");
        bcast(4'd1, 32'h2A, 1'b0, 32'h0);
        idle();
        cycle();
        chk(32'(reg_en), 32'd1, "tp1_en");
        chk(32'(reg_rd), 32'd5, "tp1_rd");
        chk(reg_value, 32'h2A, "tp1_value");
        chk(32'(reg_tag), 32'd1, "tp1_tag");

        // Fill all fifteen entries, then free one.
        do_reset();
        for (int i = 0; i < 15; i++) disp(OP_ALU, 5'(i + 1), 32'h400 + 32'(i * 4), 1'b0);
        chk(32'(full_out), 32'd1, "full_set");
        chk(32'(b_out), 32'd1, "full_b_wrap");
        bcast(4'd1, 32'h11, 1'b0, 32'h0);
        idle();
        cycle();
        chk(32'(full_out), 32'd0, "full_drop");
        chk(32'(b_out), 32'd1, "realloc_tag");
        disp(OP_ALU, 5'd9, 32'h500, 1'b0);
        chk(32'(full_out), 32'd1, "full_again");

        // Lookup with and without CDB bypass.
        do_reset();
        for (int i = 0; i < 3; i++) disp(OP_ALU, 5'd4, 32'h600, 1'b0);
        idle();
        rs_h = 4'd3;
        #1;
        chk(32'(rs_ready), 32'd0, "lk_not_ready");
        chk(32'(rt_ready), 32'd0, "lk_h0_ready");
        chk(rt_value, 32'd0, "lk_h0_value");
        cycle();
        idle();
        rs_h = 4'd3; cdb_en = 1'b1; cdb_tag = 4'd3; cdb_value = 32'hDEAD;
        #1;
        chk(32'(rs_ready), 32'd1, "lk_bypass_ready");
        chk(rs_value, 32'hDEAD, "lk_bypass_value");
        cycle();
        idle();
        rt_h = 4'd3;
        cycle();

        // Mispredicted branch flushes younger entries.
        do_reset();
        disp(OP_BEQ, 5'd0, 32'h200, 1'b0);
        disp(OP_ALU, 5'd3, 32'h204, 1'b0);
        disp(OP_ALU, 5'd4, 32'h208, 1'b0);
        bcast(4'd1, 32'h0, 1'b1, 32'h240);
        idle();
        cycle();
        chk(32'(bp_en), 32'd1, "br_bp_en");
        chk(bp_pc, 32'h200, "br_bp_pc");
        chk(32'(bp_taken), 32'd1, "br_bp_taken");
        chk(32'(flush), 32'd1, "br_flush");
        chk(pc_target, 32'h240, "br_target");
        chk(32'(b_out), 32'd1, "br_b_out");
        chk(32'(full_out), 32'd0, "br_full");
        idle();
        cycle();
        chk(32'(flush), 32'd0, "br_flush_pulse");

        // Out-of-order completion, then a store.
        do_reset();
        disp(OP_ALU, 5'd1, 32'h700, 1'b0);
        disp(OP_ALU, 5'd2, 32'h704, 1'b0);
        disp(OP_SW, 5'd0, 32'h708, 1'b0);
        bcast(4'd2, 32'h22, 1'b0, 32'h0);
        idle();
        cycle();
        chk(32'(reg_en), 32'd0, "ooo_hold");
        bcast(4'd1, 32'h11, 1'b0, 32'h0);
        bcast(4'd3, 32'h33, 1'b0, 32'h0);
        chk(32'(reg_tag), 32'd1, "ooo_first");
        idle();
        cycle();
        chk(32'(reg_en), 32'd1, "ooo_second_en");
        chk(32'(reg_tag), 32'd2, "ooo_second");
        idle();
        cycle();
        chk(32'(st_en), 32'd1, "st_en");
        chk(32'(reg_en), 32'd0, "st_no_reg");
        chk(32'(st_tag), 32'd3, "st_tag");

        // Reset during a commit pulse, then a stalled commit.
        do_reset();
        disp(OP_ALU, 5'd7, 32'h800, 1'b0);
        disp(OP_ALU, 5'd8, 32'h804, 1'b0);
        bcast(4'd1, 32'h77, 1'b0, 32'h0);
        idle();
        cycle();
        chk(32'(reg_en), 32'd1, "pre_reset_en");
        do_reset();
        disp(OP_ALU, 5'd9, 32'h900, 1'b0);
        bcast(4'd1, 32'h99, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            rdy = 1'b0;
            cycle();
            chk(32'(reg_en), 32'd0, "stall_no_commit");
        end
        idle();
        cycle();
        chk(32'(reg_en), 32'd1, "stall_release_en");
        chk(32'(reg_rd), 32'd9, "stall_release_rd");

        // Randomized traffic against the queue model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if (rob_q.size() < 15 && $urandom_range(0, 1) == 1) begin
                disp_en = 1'b1;
                disp_op = ops[$urandom_range(0, 7)];
                disp_dest = 5'($urandom_range(0, 31));
                disp_pc = $urandom;
                disp_taken = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) != 0) begin
                cdb_en = 1'b1;
                if (rob_q.size() != 0 && $urandom_range(0, 3) != 0)
                    cdb_tag = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
                else
                    cdb_tag = 4'($urandom_range(0, 15));
                cdb_value = $urandom;
                cdb_taken = 1'($urandom_range(0, 1));
                cdb_target = $urandom;
            end
            rs_h = 4'($urandom_range(0, 15));
            rt_h = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
